cpu_icache: RTL and testbench
=============================

CPU_ICACHE -- requirements
Module: cpu_icache

Interface
REQ-001 Parameter: INDEX_BITS, default 10, log2 of cache line count (one 32-bit word per line, 1024 lines).
REQ-002 Clock and reset are decided: reset i_reset, synchronous, active-high; clock i_clock.
REQ-003 i_clock  input  1  rising-edge clock for all state.
REQ-004 i_reset  input  1  synchronous active-high reset.
REQ-005 i_input_pc  input  32  instruction address to look up; word aligned, bits [1:0] ignored.
REQ-006 i_stall  input  1  high: no new miss fill may be started.
REQ-007 o_rdata  output  32  instruction word for i_input_pc, valid when o_ready=1.
REQ-008 o_ready  output  1  high: o_rdata holds the word for the current i_input_pc.
REQ-009 o_bus_request  output  1  registered read request to memory bus.
REQ-010 i_bus_ready  input  1  bus read complete; i_bus_rdata valid this cycle.
REQ-011 o_bus_address  output  32  registered fill address, {pc[31:2],2'b00}.
REQ-012 i_bus_rdata  input  32  bus read data.

Function
REQ-013 Direct-mapped organisation: index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]; per line one valid bit, tag and data word.
REQ-014 States: FLUSH, IDLE, FILL.
REQ-015 Lookup is combinational: hit = valid[index] && tag[index]==pc tag; o_ready = hit && state==IDLE; o_rdata = data[index].
REQ-016 IDLE, miss, i_stall=0: latch pc, next edge assert o_bus_request=1 and o_bus_address=latched word address, enter FILL.
REQ-017 IDLE, miss, i_stall=1: no request issued; remain IDLE, o_ready=0.
REQ-018 FILL: hold o_bus_request and o_bus_address stable until i_bus_ready=1; on that edge write data, tag, valid=1 for latched index, deassert o_bus_request, enter IDLE.
REQ-019 Miss latency: o_bus_request rises 1 cycle after the missing pc is presented; o_ready rises 1 cycle after the i_bus_ready cycle if pc is unchanged.
REQ-020 i_input_pc changing during FILL does not abort the fill; the latched address is filled and the new pc is looked up in IDLE.
REQ-021 i_stall is ignored during FILL; an in-flight fill always completes.
REQ-022 A fill to an occupied line overwrites it (no replacement policy beyond direct mapping).
REQ-023 o_ready is 0 in FLUSH and FILL.

Reset
REQ-024 i_reset: state=FLUSH, flush counter=0, o_bus_request=0, o_bus_address=0; any in-flight fill is abandoned without writing.
REQ-025 FLUSH clears one valid bit per cycle, 2^INDEX_BITS cycles, then enters IDLE; no bus activity during FLUSH.
REQ-026 After flush all lines are invalid; first lookup of any pc misses.

Configuration
REQ-027 Macro CPU_ICACHE_EN defined: full array of 2^INDEX_BITS lines as above.
REQ-028 CPU_ICACHE_EN undefined: no array and no FLUSH; a single-entry buffer (last filled address+data, valid cleared on reset) replaces it, so only re-reads of the last fetched address hit; handshake and latencies otherwise identical; reset enters IDLE directly.

Verification
REQ-029 Reset, then wait 1024 cycles: o_ready=0 and o_bus_request=0 throughout flush; state IDLE after.
REQ-030 pc=0x00000100, stall=0, bus returns 0x00000013 after 3 cycles -> o_bus_address=0x00000100 held, request drops after ready, next cycle o_ready=1, o_rdata=0x00000013.
REQ-031 Re-present pc=0x00000100 -> o_ready=1 same cycle, no bus request.
REQ-032 pc=0x00001100 (same index, different tag) -> miss and fill; then pc=0x00000100 misses again.
REQ-033 Miss with i_stall=1 for 5 cycles -> no request; drop stall -> request next cycle.
REQ-034 Assert i_reset during FILL -> o_bus_request=0 next cycle, line not written, flush restarts.

Source files
------------

// File: rtl/cpu_icache_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_icache_if
// Description : Fetch-side and memory-bus signals of the instruction cache.
//               slave  = the cache itself
//               master = the environment (fetch unit plus memory bus)
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_icache_if;
    logic [31:0] i_input_pc;
    logic        i_stall;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_bus_request;
    logic        i_bus_ready;
    logic [31:0] o_bus_address;
    logic [31:0] i_bus_rdata;

    modport slave (
        input  i_input_pc, i_stall, i_bus_ready, i_bus_rdata,
        output o_rdata, o_ready, o_bus_request, o_bus_address
    );

    modport master (
        output i_input_pc, i_stall, i_bus_ready, i_bus_rdata,
        input  o_rdata, o_ready, o_bus_request, o_bus_address
    );
endinterface
`default_nettype wire

// File: rtl/cpu_icache.sv
`default_nettype none
// ============================================================================
// Module      : cpu_icache
// Description : Direct-mapped instruction cache, one 32-bit word per line.
//               Combinational lookup, single outstanding miss fill.
//               Build option CPU_ICACHE_EN:
//                 defined   - full array of 2^INDEX_BITS lines, flushed after
//                             reset one valid bit per cycle
//                 undefined - single-entry buffer holding the last filled
//                             word, no flush
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_icache #(
    parameter int INDEX_BITS = 10
) (
    input  logic        i_clock,
    input  logic        i_reset,
    cpu_icache_if.slave bus
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_IDLE  = 2'd1,
        S_FILL  = 2'd2
    } state_t;

`ifdef CPU_ICACHE_EN
    localparam state_t RESET_STATE = S_FLUSH;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_bus_request;
    logic [31:0]           r_bus_address;
    logic                  w_start_fill;
    logic                  w_fill_done;
    logic                  w_fill_write;
    logic                  w_hit;
    logic                  w_flush_last;
    logic [31:0]           w_line_data;
    logic [INDEX_BITS-1:0] w_pc_index;
    logic [TAG_BITS-1:0]   w_pc_tag;
    logic                  w_unused_bits;

    assign w_pc_index    = bus.i_input_pc[INDEX_BITS+1:2];
    assign w_pc_tag      = bus.i_input_pc[31:INDEX_BITS+2];
    // Byte-offset bits are word aligned by construction and carry no information.
    assign w_unused_bits = ^{bus.i_input_pc[1:0], r_bus_address[1:0]};

    // A fill response arriving in the same cycle as reset is discarded.
    assign w_fill_write  = w_fill_done && !i_reset;

`ifdef CPU_ICACHE_EN
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES];
    logic [INDEX_BITS-1:0] r_flush_count;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;

    assign w_fill_index = r_bus_address[INDEX_BITS+1:2];
    assign w_fill_tag   = r_bus_address[31:INDEX_BITS+2];
    assign w_hit        = r_valid[w_pc_index] && (r_tag[w_pc_index] == w_pc_tag);
    assign w_line_data  = r_data[w_pc_index];
    assign w_flush_last = (r_flush_count == {INDEX_BITS{1'b1}});

    // Flush walk pointer: restarts on reset, advances once per FLUSH cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_flush_count <= '0;
        end else if (r_state == S_FLUSH) begin
            r_flush_count <= r_flush_count + 1'b1;
        end
    end

    // Valid bits: cleared one per cycle while flushing, set by a completed fill.
    always_ff @(posedge i_clock) begin
        if (r_state == S_FLUSH) begin
            r_valid[r_flush_count] <= 1'b0;
        end else if (w_fill_write) begin
            r_valid[w_fill_index] <= 1'b1;
        end
    end

    // Tag and data arrays: written only when a fill completes.
    always_ff @(posedge i_clock) begin
        if (w_fill_write) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= bus.i_bus_rdata;
        end
    end
`else
    logic        r_buf_valid;
    logic [29:0] r_buf_addr;
    logic [31:0] r_buf_data;

    assign w_hit        = r_buf_valid && (r_buf_addr == {w_pc_tag, w_pc_index});
    assign w_line_data  = r_buf_data;
    assign w_flush_last = 1'b1;

    // Single-entry buffer: remembers the most recently filled word.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_buf_valid <= 1'b0;
        end else if (w_fill_write) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= r_bus_address[31:2];
            r_buf_data  <= bus.i_bus_rdata;
        end
    end
`endif

    // Controller state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: start a fill on an unstalled miss, finish on bus ready.
    always_comb begin
        w_next_state = r_state;
        w_start_fill = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            S_FLUSH: begin
                if (w_flush_last) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!w_hit && !bus.i_stall) begin
                    w_start_fill = 1'b1;
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.i_bus_ready) begin
                    w_fill_done  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = RESET_STATE;
            end
        endcase
    end

    // Bus request/address registers: latched at miss, held until the fill returns.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bus_request <= 1'b0;
            r_bus_address <= '0;
        end else if (w_start_fill) begin
            r_bus_request <= 1'b1;
            r_bus_address <= {bus.i_input_pc[31:2], 2'b00};
        end else if (w_fill_done) begin
            r_bus_request <= 1'b0;
        end
    end

    assign bus.o_ready       = w_hit && (r_state == S_IDLE);
    assign bus.o_rdata       = w_line_data;
    assign bus.o_bus_request = r_bus_request;
    assign bus.o_bus_address = r_bus_address;

endmodule
`default_nettype wire

// File: tb/tb_cpu_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_icache
// Description : Directed self-checking bench for cpu_icache. Expectations
//               follow the build option CPU_ICACHE_EN (array vs single entry).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_icache;

`ifdef CPU_ICACHE_EN
    localparam logic EN = 1'b1;
`else
    localparam logic EN = 1'b0;
`endif
    // While waiting out the flush, the array build keeps stall low so that any
    // premature exit from FLUSH shows up as a bus request; the single-entry
    // build has no flush and must be kept quiet instead.
    localparam logic FLUSH_STALL = ~EN;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cpu_icache_if bus ();

    cpu_icache #(.INDEX_BITS(10)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_flush();
        for (int i = 0; i < 1023; i++) begin
            tick();
            check("flush_ready", bus.o_ready, 32'd0);
            check("flush_request", bus.o_bus_request, 32'd0);
        end
        tick();
    endtask

    initial begin
        rst               = 1'b1;
        bus.i_input_pc    = 32'h0;
        bus.i_stall       = FLUSH_STALL;
        bus.i_bus_ready   = 1'b0;
        bus.i_bus_rdata   = 32'h0;
        tick();
        tick();
        check("reset_request", bus.o_bus_request, 32'd0);
        check("reset_address", bus.o_bus_address, 32'h0);
        check("reset_ready", bus.o_ready, 32'd0);
        rst = 1'b0;
        wait_flush();

        // First miss with a 3-cycle bus response.
        bus.i_input_pc = 32'h0000_0100;
        bus.i_stall    = 1'b0;
        #1;
        check("miss_ready", bus.o_ready, 32'd0);
        check("miss_no_request_yet", bus.o_bus_request, 32'd0);
        tick();
        check("req_rise", bus.o_bus_request, 32'd1);
        check("req_addr", bus.o_bus_address, 32'h0000_0100);
        check("fill_ready_low", bus.o_ready, 32'd0);
        tick();
        check("req_held1", bus.o_bus_request, 32'd1);
        check("addr_held1", bus.o_bus_address, 32'h0000_0100);
        tick();
        check("req_held2", bus.o_bus_request, 32'd1);
        bus.i_bus_ready = 1'b1;
        bus.i_bus_rdata = 32'h0000_0013;
        tick();
        bus.i_bus_ready = 1'b0;
        bus.i_bus_rdata = 32'hDEAD_BEEF;
        #1;
        check("req_drop", bus.o_bus_request, 32'd0);
        check("fill_ready", bus.o_ready, 32'd1);
        check("fill_rdata", bus.o_rdata, 32'h0000_0013);

        // Re-read hits with no bus activity.
        tick();
        check("hit_ready", bus.o_ready, 32'd1);
        check("hit_rdata", bus.o_rdata, 32'h0000_0013);
        check("hit_no_request", bus.o_bus_request, 32'd0);

        // Same index, different tag: miss, fill, then the old address misses.
        bus.i_input_pc = 32'h0000_1100;
        #1;
        check("alias_miss", bus.o_ready, 32'd0);
        tick();
        check("alias_req", bus.o_bus_request, 32'd1);
        check("alias_addr", bus.o_bus_address, 32'h0000_1100);
        bus.i_bus_ready = 1'b1;
        bus.i_bus_rdata = 32'h0050_0093;
        tick();
        bus.i_bus_ready = 1'b0;
        #1;
        check("alias_req_drop", bus.o_bus_request, 32'd0);
        check("alias_ready", bus.o_ready, 32'd1);
        check("alias_rdata", bus.o_rdata, 32'h0050_0093);
        bus.i_input_pc = 32'h0000_0100;
        #1;
        check("evicted_miss", bus.o_ready, 32'd0);
        tick();
        check("evicted_req", bus.o_bus_request, 32'd1);
        check("evicted_addr", bus.o_bus_address, 32'h0000_0100);
        bus.i_bus_ready = 1'b1;
        bus.i_bus_rdata = 32'h0000_0013;
        tick();
        bus.i_bus_ready = 1'b0;
        #1;
        check("refill_rdata", bus.o_rdata, 32'h0000_0013);

        // A different index leaves 0x100 resident only in the array build.
        bus.i_input_pc = 32'h0000_0204;
        tick();
        check("other_addr", bus.o_bus_address, 32'h0000_0204);
        bus.i_bus_ready = 1'b1;
        bus.i_bus_rdata = 32'h1111_1111;
        tick();
        bus.i_bus_ready = 1'b0;
        bus.i_input_pc  = 32'h0000_0100;
        #1;
        check("keep_ready", bus.o_ready, {31'd0, EN});
        check("keep_rdata", bus.o_rdata, EN ? 32'h0000_0013 : 32'h1111_1111);
        tick();
        check("keep_request", bus.o_bus_request, {31'd0, ~EN});
        if (!EN) begin
            bus.i_bus_ready = 1'b1;
            bus.i_bus_rdata = 32'h0000_0013;
            tick();
            bus.i_bus_ready = 1'b0;
        end

        // PC change and stall during a fill do not disturb it.
        bus.i_input_pc = 32'h0000_0300;
        tick();
        check("pcchg_req", bus.o_bus_request, 32'd1);
        bus.i_input_pc = 32'h0000_0400;
        bus.i_stall    = 1'b1;
        tick();
        check("pcchg_addr_held", bus.o_bus_address, 32'h0000_0300);
        check("pcchg_req_held", bus.o_bus_request, 32'd1);
        check("pcchg_ready_low", bus.o_ready, 32'd0);
        bus.i_bus_ready = 1'b1;
        bus.i_bus_rdata = 32'h0000_0033;
        tick();
        bus.i_bus_ready = 1'b0;
        #1;
        check("pcchg_done", bus.o_bus_request, 32'd0);
        check("pcchg_new_miss", bus.o_ready, 32'd0);
        tick();
        check("pcchg_stalled", bus.o_bus_request, 32'd0);
        bus.i_stall = 1'b0;
        tick();
        check("pcchg_new_req", bus.o_bus_address, 32'h0000_0400);
        bus.i_bus_ready = 1'b1;
        bus.i_bus_rdata = 32'h0000_0044;
        tick();
        bus.i_bus_ready = 1'b0;
        #1;
        check("pcchg_new_rdata", bus.o_rdata, 32'h0000_0044);
        bus.i_input_pc = 32'h0000_0300;
        #1;
        check("pcchg_old_ready", bus.o_ready, {31'd0, EN});
        check("pcchg_old_rdata", bus.o_rdata, EN ? 32'h0000_0033 : 32'h0000_0044);

        // Stalled miss issues nothing until stall drops.
        bus.i_input_pc = 32'h0000_0500;
        bus.i_stall    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_req", bus.o_bus_request, 32'd0);
            check("stall_ready", bus.o_ready, 32'd0);
        end
        bus.i_stall = 1'b0;
        tick();
        check("unstall_req", bus.o_bus_request, 32'd1);
        check("unstall_addr", bus.o_bus_address, 32'h0000_0500);
        bus.i_stall     = 1'b1;
        bus.i_bus_ready = 1'b1;
        bus.i_bus_rdata = 32'h0000_0055;
        tick();
        bus.i_bus_ready = 1'b0;
        #1;
        check("stallfill_req_drop", bus.o_bus_request, 32'd0);
        check("stallfill_ready", bus.o_ready, 32'd1);
        check("stallfill_rdata", bus.o_rdata, 32'h0000_0055);

        // Reset during a fill abandons it and restarts the flush.
        bus.i_input_pc = 32'h0000_0600;
        bus.i_stall    = 1'b0;
        tick();
        check("rstfill_req", bus.o_bus_request, 32'd1);
        rst             = 1'b1;
        bus.i_bus_ready = 1'b1;
        bus.i_bus_rdata = 32'h0000_0066;
        tick();
        check("rstfill_req_low", bus.o_bus_request, 32'd0);
        check("rstfill_addr_zero", bus.o_bus_address, 32'h0);
        check("rstfill_ready_low", bus.o_ready, 32'd0);
        rst             = 1'b0;
        bus.i_bus_ready = 1'b0;
        bus.i_stall     = FLUSH_STALL;
        wait_flush();
        bus.i_stall = 1'b0;
        #1;
        check("rstfill_not_written", bus.o_ready, 32'd0);
        tick();
        check("rstfill_refetch_req", bus.o_bus_request, 32'd1);
        check("rstfill_refetch_addr", bus.o_bus_address, 32'h0000_0600);
        bus.i_bus_ready = 1'b1;
        tick();
        bus.i_bus_ready = 1'b0;
        #1;
        check("rstfill_final_ready", bus.o_ready, 32'd1);
        check("rstfill_final_rdata", bus.o_rdata, 32'h0000_0066);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
